// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake for the UART receive FIFO.
// master = FIFO (producer), slave = consumer.
interface uart_rx_fifo_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO.
// Reports framing errors and overruns as one-cycle pulses.
module uart_rx_fifo #(
  parameter  int CLK_DIV = 434,
  parameter  int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  uart_rx_fifo_if.master  rd,
  output logic [AW:0]     level,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync_q, rx_s, rx_q;
  logic          push, ferr_d, ovr_d;
  logic          ferr_q, ovr_q;
  logic          tick;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full, pop, wr_en, valid;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = FULL;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = FULL;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          push    = rx_s;
          ferr_d  = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full when pointers differ only in the wrap bit.
  assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign valid = (level_q != '0);
  assign pop   = valid && rd.rd_ready;
  assign wr_en = push && (!full || pop);
  assign ovr_d = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (wr_en && !pop): level_d = level_q + 1'b1;
      (pop && !wr_en): level_d = level_q - 1'b1;
      default:         level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 1'b1;
      rx_s     <= 1'b1;
      rx_q     <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      sync_q   <= uart_rx;
      rx_s     <= sync_q;
      rx_q     <= rx_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign rd.rd_valid = valid;
  assign rd.rd_data  = valid ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign level       = level_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, scoreboard on the
// read handshake, pulse counters for frame_err/overrun.
module tb_uart_rx_fifo;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic [AW:0] level;
  logic        frame_err, overrun, busy;

  uart_rx_fifo_if rif();

  uart_rx_fifo #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rd        (rif.master),
    .level     (level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Monitor: compare every accepted byte against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rif.rd_valid && rif.rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got %0h expected none",
                   rif.rd_data);
        end else begin
          chk("rd_data", int'(rif.rd_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    uart_rx = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CLK_DIV);
    end
    uart_rx = stp;
    tick(CLK_DIV);
    uart_rx = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rif.rd_ready = 1'b1;
    while (rif.rd_valid && n < 64) begin
      tick(1);
      n++;
    end
    rif.rd_ready = 1'b0;
    chk("drain_empty", int'(rif.rd_valid), 0);
    chk("drain_level", int'(level), 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, int'(rif.rd_valid), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_data"}, int'(rif.rd_data), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int lat, nb, fe0, ov0;
    rst = 1'b1;
    uart_rx = 1'b1;
    rif.rd_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk_reset("rst");
    tick(4);

    // 1: single byte, latency and one-cycle pop
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send(8'hA5, 1'b1);
      begin
        while (!rif.rd_valid && lat < 120) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("t1_lat_ok", int'(lat >= 70 && lat <= 90), 1);
    chk("t1_level", int'(level), 1);
    chk("t1_ferr", fe_cnt - fe0, 0);
    chk("t1_ovr", ov_cnt - ov0, 0);
    rif.rd_ready = 1'b1;
    tick(1);
    rif.rd_ready = 1'b0;
    chk("t1_valid_after", int'(rif.rd_valid), 0);
    chk("t1_level_after", int'(level), 0);
    chk("t1_sb", exp_q.size(), 0);
    tick(4);

    // 2: short glitch is rejected
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    nb = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("t2_busy_seen", int'(nb > 0), 1);
    chk("t2_busy_short", int'(nb <= CLK_DIV / 2 + 3), 1);
    chk("t2_idle", int'(busy), 0);
    chk("t2_level", int'(level), 0);
    chk("t2_ferr", fe_cnt - fe0, 0);
    tick(1);

    // 3: framing error, long break, then a clean byte
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    tick(2 * CLK_DIV);
    chk("t3_ferr_once", fe_cnt - fe0, 1);
    chk("t3_level", int'(level), 0);
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    tick(15 * CLK_DIV);
    uart_rx = 1'b1;
    tick(2 * CLK_DIV);
    chk("t3_break_once", fe_cnt - fe0, 1);
    chk("t3_break_level", int'(level), 0);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    tick(4);
    chk("t3_level_11", int'(level), 1);
    drain();
    tick(4);

    // 4: overflow by one byte, back-to-back frames
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    tick(2);
    chk("t4_no_ovr_yet", ov_cnt - ov0, 0);
    chk("t4_level_full", int'(level), 16);
    send(8'h10, 1'b1);
    tick(4);
    chk("t4_ovr_once", ov_cnt - ov0, 1);
    chk("t4_level_still", int'(level), 16);
    drain();
    tick(4);

    // 5: pop in the stop-sample cycle while full
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send(8'(8'h20 + i), 1'b1);
    end
    tick(2);
    chk("t5_level_full", int'(level), 16);
    exp_q.push_back(8'h10);
    fork
      send(8'h10, 1'b1);
      begin
        tick(10 * CLK_DIV - 2);
        rif.rd_ready = 1'b1;
        tick(1);
        rif.rd_ready = 1'b0;
      end
    join
    tick(4);
    chk("t5_no_ovr", ov_cnt - ov0, 0);
    chk("t5_level", int'(level), 16);
    chk("t5_sb_left", exp_q.size(), 16);
    drain();
    tick(4);

    // 6: reset mid-frame with bytes queued
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    tick(2);
    chk("t6_level3", int'(level), 3);
    uart_rx = 1'b0;
    tick(CLK_DIV);
    uart_rx = 1'b1;
    tick(20);
    chk("t6_busy_mid", int'(busy), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("t6_rst");
    tick(12 * CLK_DIV);
    chk("t6_idle", int'(busy), 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    tick(4);
    chk("t6_level_5a", int'(level), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
